// File: rtl/fifo_write_controller_if.sv
// fifo_write_controller_if: producer and RAM-side signals of the FIFO write controller
interface fifo_write_controller_if #(parameter int depth = 8);
  logic wr_req;
  logic [depth-1:0] rd_gray_value;
  logic wr_en;
  logic [depth-2:0] wr_address;
  logic [depth-1:0] gray_value;
  logic full;
  logic almost_full;
  logic [depth-1:0] level;
  logic overflow;
  modport master (
    output wr_req, rd_gray_value,
    input wr_en, wr_address, gray_value, full, almost_full, level, overflow
  );
  modport slave (
    input wr_req, rd_gray_value,
    output wr_en, wr_address, gray_value, full, almost_full, level, overflow
  );
endinterface

// File: rtl/fifo_write_controller.sv
// fifo_write_controller: write-side pointer, read-pointer synchroniser and full/level flags of a dual-clock FIFO
module fifo_write_controller #(
  parameter int depth = 8,
  parameter int almost_full_level = 2 ** (depth - 1) - 2
) (
  input logic wr_clock,
  input logic reset,
  fifo_write_controller_if.slave bus
);
  localparam logic [depth-1:0] af_level = depth'(almost_full_level);
  logic [depth-1:0] wr_bin, next_bin, gray, sync1, sync2, rd_bin_sync;
  logic ovf;
  assign bus.wr_en = bus.wr_req & ~bus.full & ~reset;
  assign next_bin = wr_bin + {{(depth-1){1'b0}}, bus.wr_en};
  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i < depth; i++) rd_bin_sync[i] = ^(sync2 >> i);
  end
  assign bus.level = wr_bin - rd_bin_sync;
  // full when the write pointer is exactly one lap ahead of the synchronised read pointer
  assign bus.full = gray == {~sync2[depth-1:depth-2], sync2[depth-3:0]};
  assign bus.almost_full = bus.level >= af_level;
  assign bus.wr_address = wr_bin[depth-2:0];
  assign bus.gray_value = gray;
  assign bus.overflow = ovf;
  always_ff @(posedge wr_clock) begin
    if (reset) begin
      wr_bin <= '0;
      gray <= '0;
      sync1 <= '0;
      sync2 <= '0;
      ovf <= 1'b0;
    end else begin
      wr_bin <= next_bin;
      gray <= next_bin ^ (next_bin >> 1);
      sync1 <= bus.rd_gray_value;
      sync2 <= sync1;
      if (bus.wr_req & bus.full) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_write_controller.sv
// tb_fifo_write_controller: vector table for reset/fill/overflow/drain/reset, scoreboard for wrap-around
module tb_fifo_write_controller;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  fifo_write_controller_if #(.depth(4)) bus ();
  fifo_write_controller #(.depth(4), .almost_full_level(6)) dut (
    .wr_clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );
  typedef struct {
    logic r;
    logic q;
    logic [3:0] rg;
    logic en;
    logic [2:0] a;
    logic [3:0] g;
    logic f;
    logic af;
    logic [3:0] l;
    logic o;
  } vec_t;
  typedef struct {
    logic [2:0] a;
    logic [3:0] g;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] g(input int x);
    logic [3:0] b;
    b = 4'(x);
    return b ^ (b >> 1);
  endfunction
  initial begin
    logic [3:0] gtab[8];
    int s1, s2, rd, wr;
    exp_t e;
    gtab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    repeat (2) tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{0, 1, 0, 1, 3'(k % 8), gtab[k-1], k == 8, k >= 6, 4'(k), 0});
    tbl.push_back('{0, 1, 0, 0, 0, 4'b1100, 1, 1, 8, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 4'b1100, 1, 1, 8, 1});
    tbl.push_back('{0, 0, 4'b0001, 0, 0, 4'b1100, 1, 1, 8, 1});
    tbl.push_back('{0, 0, 4'b0001, 0, 0, 4'b1100, 0, 1, 7, 1});
    tbl.push_back('{0, 1, 4'b0001, 1, 1, 4'b1101, 1, 1, 8, 1});
    tbl.push_back('{0, 0, 4'b0110, 0, 1, 4'b1101, 1, 1, 8, 1});
    tbl.push_back('{0, 0, 4'b0110, 0, 1, 4'b1101, 0, 0, 5, 1});
    tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    repeat (2) tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      rst = tbl[i].r;
      bus.wr_req = tbl[i].q;
      bus.rd_gray_value = tbl[i].rg;
      #1;
      chk($sformatf("v%0d_wr_en", i), 16'(bus.wr_en), 16'(tbl[i].en));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_addr", i), 16'(bus.wr_address), 16'(tbl[i].a));
      chk($sformatf("v%0d_gray", i), 16'(bus.gray_value), 16'(tbl[i].g));
      chk($sformatf("v%0d_full", i), 16'(bus.full), 16'(tbl[i].f));
      chk($sformatf("v%0d_afull", i), 16'(bus.almost_full), 16'(tbl[i].af));
      chk($sformatf("v%0d_level", i), 16'(bus.level), 16'(tbl[i].l));
      chk($sformatf("v%0d_ovf", i), 16'(bus.overflow), 16'(tbl[i].o));
    end
    s1 = 0;
    s2 = 0;
    wr = 0;
    for (int n = 1; n <= 20; n++) begin
      rd = n - 1;
      bus.wr_req = 1'b1;
      bus.rd_gray_value = g(rd);
      #1;
      chk($sformatf("w%0d_wr_en", n), 16'(bus.wr_en), 16'd1);
      wr++;
      sb.push_back('{3'(wr % 8), g(wr % 16)});
      @(posedge clk);
      #1;
      s2 = s1;
      s1 = rd;
      e = sb.pop_front();
      chk($sformatf("w%0d_addr", n), 16'(bus.wr_address), 16'(e.a));
      chk($sformatf("w%0d_gray", n), 16'(bus.gray_value), 16'(e.g));
      chk($sformatf("w%0d_level", n), 16'(bus.level), 16'((wr - s2) & 15));
      chk($sformatf("w%0d_lvl_bound", n), 16'(bus.level <= 4'd2), 16'd1);
      chk($sformatf("w%0d_full", n), 16'(bus.full), 16'd0);
      chk($sformatf("w%0d_ovf", n), 16'(bus.overflow), 16'd0);
      bus.wr_req = 1'b0;
      @(posedge clk);
      #1;
      s2 = s1;
      chk($sformatf("i%0d_level", n), 16'(bus.level), 16'((wr - s2) & 15));
      chk($sformatf("i%0d_full", n), 16'(bus.full), 16'd0);
    end
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_write_controller.md
Name: fifo_write_controller

Overview:
- Write-side pointer logic of the dual-clock FIFO. It pairs with the existing FIFO read controller, which drives a Gray-coded read pointer from the rd_clock domain.
- Holds the binary write pointer and drives the RAM write address and write enable.
- Publishes its own Gray-coded pointer to the read domain.
- Synchronises the incoming read Gray pointer into wr_clock and derives full, almost_full, level and a sticky overflow flag.

Parameters:
- depth, 8, pointer width in bits (matches the read controller's depth). RAM address width is depth-1, so capacity is 2^(depth-1) words. Legal range depth >= 3.
- almost_full_level, 2^(depth-1)-2, level at or above which almost_full asserts. Legal range 1..2^(depth-1).

Ports:
- wr_clock  input  1  write-domain clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset sampled on wr_clock.
- wr_req  input  1  producer requests a write this cycle.
- rd_gray_value  input  depth  Gray read pointer from the read controller; asynchronous to wr_clock.
- wr_en  output  1  RAM write strobe; wr_req & ~full.
- wr_address  output  depth-1  RAM write address; low depth-1 bits of the binary write pointer.
- gray_value  output  depth  registered Gray write pointer, sent to the read domain.
- full  output  1  FIFO holds 2^(depth-1) words.
- almost_full  output  1  level >= almost_full_level.
- level  output  depth  occupancy as seen from the write domain, 0..2^(depth-1).
- overflow  output  1  sticky: wr_req was asserted while full.

Behaviour:
- One clock, wr_clock. Reset is synchronous and active-high. Every register clears on the first rising edge with reset=1.
- Outputs during and after reset: wr_en=0 (wr_req is ignored while reset=1), wr_address=0, gray_value=0, full=0, almost_full=0, level=0, overflow=0.
- Binary write pointer wr_bin (depth bits):
  - wr_bin <= wr_bin + 1 when wr_en=1, else it holds.
  - It wraps modulo 2^depth; the MSB is the lap bit.
- gray_value register <= next_bin ^ (next_bin >> 1), where next_bin is the value wr_bin takes on the same edge.
  - This keeps gray_value glitch-free and in the same cycle as wr_bin.
  - It uses the same Gray encoding as the read controller.
  - Exactly one bit of gray_value changes per accepted write.
- Read-pointer synchroniser:
  - Two-stage register chain sync1 <= rd_gray_value; sync2 <= sync1.
  - No logic between the stages.
  - Both stages clear to 0 on reset.
- rd_bin_sync = Gray-to-binary of sync2; bit i is the XOR of sync2[depth-1:i].
- level = (wr_bin - rd_bin_sync) mod 2^depth. Combinational from registers, so it is valid the same cycle as the register values.
- full = (gray_value == {~sync2[depth-1:depth-2], sync2[depth-3:0]}). This is equivalent to level == 2^(depth-1).
- Latency:
  - A write accepted in cycle t is reflected in wr_address, gray_value, level and full from cycle t+1.
  - A change on rd_gray_value is reflected in level and full after 2 wr_clock edges.
  - The full flag is therefore pessimistic, never optimistic, so no write is ever lost to a stale flag.
- wr_req=1 while full=1:
  - wr_en=0 and the pointer holds.
  - overflow sets on that edge and remains set until reset.
- Wrap-around: wr_bin goes (2^depth)-1 -> 0 and wr_address goes (2^(depth-1))-1 -> 0 with no special handling.
- Simultaneous write and read-pointer advance:
  - Both take effect independently.
  - level may be unchanged, or transiently differ by one because of synchroniser latency.
- Reset mid-operation:
  - All state clears at the next edge regardless of wr_req.
  - Pending occupancy is discarded.
  - The read controller must be reset in the same window (system requirement, not checked here).
  - After both sides are out of reset, a stale rd_gray_value inside the synchroniser clears within 2 edges.

Test Plan (depth=4, capacity 8, almost_full_level=6):
1. Reset: hold reset=1 for 2 cycles with wr_req=1 -> wr_en=0, wr_address=0, gray_value=0, level=0, full=0, overflow=0.
2. Fill: rd_gray_value=0, wr_req=1 for 8 cycles.
   - wr_address steps 0..7.
   - gray_value steps 0001,0011,0010,0110,0111,0101,0100,1100.
   - almost_full=1 from the cycle after the 6th write.
   - full=1 and level=8 from the cycle after the 8th write.
3. Overflow: from the full state, wr_req=1 for 1 cycle -> wr_en=0, gray_value stays 1100, overflow=1 and remains 1 after wr_req drops.
4. Drain visibility: from full, set rd_gray_value=0001 -> full and level unchanged after 1 edge; full=0 and level=7 after the 2nd edge; the next wr_req is accepted.
5. Wrap: alternate writes with rd_gray_value tracking 2 behind, for 20 writes.
   - wr_bin passes 15->0.
   - gray_value passes 1000->0000.
   - wr_address passes 7->0.
   - level never exceeds 2, full never asserts, overflow stays 0.
6. Reset mid-operation: at level=5 with overflow=1, pulse reset for 1 cycle while wr_req=1 -> next cycle level=0, full=0, overflow=0, gray_value=0, and no write is accepted in the reset cycle.
